// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer for a 4:1 select mux.
// Steps the select lines through the enabled channels. It samples the mux output a fixed
// number of cycles after each select change and builds a 4-bit frame from those samples.
// The frame is sent downstream over a valid/ready handshake.
module mux_scan_ctrl #(
    parameter int unsigned DWELL  = 4,  // cycles select is held per channel (2..255)
    parameter int unsigned SETTLE = 2   // cycles after a select change before z is sampled
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] mask,
    input  logic       z,
    output logic       s0,
    output logic       s1,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       overrun
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    // The dwell counter holds k-1 just before edge E+k, so both thresholds are one less
    // than the edge offsets they refer to.
    localparam logic [7:0] CAP_CNT = 8'(SETTLE - 1);
    localparam logic [7:0] END_CNT = 8'(DWELL - 1);

    state_t     state_q;
    logic [1:0] chan_q;
    logic [7:0] cnt_q;
    logic [3:0] shadow_q;
    logic [3:0] mask_q;
    logic [3:0] frame_q;
    logic       frame_valid_q;
    logic       overrun_q;

    logic [1:0] start_chan_d;
    logic [1:0] next_chan_d;
    logic       next_avail;
    logic       start_ok;
    logic       frame_done;

    // Returns the lowest set bit of m. The result is 0 when m is empty, and callers guard on that case.
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Returns 1 when m has a set bit above channel c.
    function automatic logic higher_exists(input logic [3:0] m, input logic [1:0] c);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && (i > int'(c))) r = 1'b1;
        end
        return r;
    endfunction

    // Returns the nearest set bit above channel c. It is only meaningful when higher_exists() is true.
    function automatic logic [1:0] next_higher(input logic [3:0] m, input logic [1:0] c);
        logic [1:0] r;
        r = c;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(c))) r = 2'(i);
        end
        return r;
    endfunction

    // Find the next channel to select and detect the edge on which the frame completes.
    always_comb begin
        start_ok     = en && (mask != 4'b0000);
        start_chan_d = lowest_set(mask);
        next_avail   = higher_exists(mask_q, chan_q);
        next_chan_d  = next_higher(mask_q, chan_q);
        frame_done   = (state_q == SCAN) && (cnt_q == END_CNT) && !next_avail;
    end

    // Scan FSM, shadow capture and output register with handshake and overrun tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            chan_q        <= 2'd0;
            cnt_q         <= 8'd0;
            shadow_q      <= 4'b0000;
            mask_q        <= 4'b0000;
            frame_q       <= 4'b0000;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register in this block update from the
            // values it held before the edge. This matters because frame_done and the shadow are read in the same edge they change.
            if (frame_done) begin
                if (!frame_valid_q || frame_ready) begin
                    frame_q       <= shadow_q;
                    frame_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (frame_valid_q && frame_ready) begin
                frame_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q  <= SCAN;
                        mask_q   <= mask;
                        chan_q   <= start_chan_d;
                        cnt_q    <= 8'd0;
                        shadow_q <= 4'b0000;
                    end
                end
                SCAN: begin
                    // SETTLE < DWELL, so this capture never falls on the completion edge.
                    if (cnt_q == CAP_CNT) shadow_q[chan_q] <= z;

                    if (cnt_q == END_CNT) begin
                        cnt_q <= 8'd0;
                        if (next_avail) begin
                            chan_q <= next_chan_d;
                        end else if (start_ok) begin
                            mask_q   <= mask;
                            chan_q   <= start_chan_d;
                            shadow_q <= 4'b0000;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s0          = chan_q[0];
    assign s1          = chan_q[1];
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;

endmodule
